hazard_ctrl: RTL

//  Pipeline hazard controller; consumes the ID/EX register outputs and drives its clear (FlushE) input.

---
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a 5-stage in-order core. It reads the ID/EX
// register outputs and drives the ID/EX clear input through FlushE. It
// produces the fetch/decode stall and flush controls and the EX-stage operand
// forwarding selects.
//
// The MEM and WB destination registers are tracked internally. A two-deep
// shadow pipe follows RdE/RegWriteE, so the core does not have to route
// RdM/RdW back to this block. Two saturating counters record stall and flush
// cycles for performance debug.
//
// States:
//   state  | meaning
//   RUN    | normal issue; flushes and the first load-use stall cycle occur here
//   LSTALL | extra load-use stall cycles while dcnt counts down (LOAD_LAT > 1)
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous reset, active low
//   Rs1D, Rs2D          source registers of the instruction in ID
//   Rs1E, Rs2E, RdE     source/destination registers in EX
//   RegWriteE           EX instruction writes the register file
//   ResultSrcE          2'b01 marks a load in EX
//   PCSrcE              taken branch / jump resolved in EX
//   StallF, StallD      hold PC / IF-ID register
//   FlushD, FlushE      clear IF-ID / ID-EX register
//   ForwardAE/BE        operand select: 00 RF, 01 WB, 10 MEM
//   stall_cnt           saturating count of cycles with StallD=1
//   flush_cnt           saturating count of cycles with FlushD=1
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic {RUN, LSTALL} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   dcnt, dcnt_nxt;
  logic [4:0]      rdm_s, rdw_s;
  logic            rwm_s, rww_s;
  logic            lw_hit;
  logic            stall, flush_d, flush_e;
  logic [1:0]      fwd_a, fwd_b;

  // MEM wins over WB because it holds the younger value; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rdm, input logic rwm,
                                         input logic [4:0] rdw, input logic rww);
    if (rwm && rdm != 5'd0 && rdm == rs)      return 2'b10;
    else if (rww && rdw != 5'd0 && rdw == rs) return 2'b01;
    else                                      return 2'b00;
  endfunction

  assign fwd_a  = fwd_sel(Rs1E, rdm_s, rwm_s, rdw_s, rww_s);
  assign fwd_b  = fwd_sel(Rs2E, rdm_s, rwm_s, rdw_s, rww_s);

  assign lw_hit = (ResultSrcE == 2'b01) && RegWriteE && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    stall     = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    case (state)
      RUN: begin
        if (PCSrcE) begin
          // A simultaneous load-use hit is dropped: its consumer is being flushed.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lw_hit) begin
          stall   = 1'b1;
          flush_e = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt = LSTALL;
            dcnt_nxt  = DW'(LOAD_LAT - 1);
          end
        end
      end
      LSTALL: begin
        if (PCSrcE) begin
          // The taken branch kills the stalled consumer, so the stall is abandoned.
          flush_d   = 1'b1;
          flush_e   = 1'b1;
          state_nxt = RUN;
          dcnt_nxt  = '0;
        end else begin
          stall   = 1'b1;
          flush_e = 1'b1;
          if (dcnt <= DW'(1)) begin
            state_nxt = RUN;
            dcnt_nxt  = '0;
          end else begin
            dcnt_nxt  = dcnt - DW'(1);
          end
        end
      end
      default: begin
        state_nxt = RUN;
        dcnt_nxt  = '0;
      end
    endcase
  end

  // The hazard outputs are combinational so a load-use stall takes effect in
  // the same cycle. They are gated by reset so they read 0 whenever reset is
  // asserted, whatever the inputs are.
  assign StallF    = reset & stall;
  assign StallD    = reset & stall;
  assign FlushD    = reset & flush_d;
  assign FlushE    = reset & flush_e;
  assign ForwardAE = reset ? fwd_a : 2'b00;
  assign ForwardBE = reset ? fwd_b : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // FlushE does not gate this update: a flushed EX already presents
  // RegWriteE=0, which is the correct value to shift into MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdm_s <= '0;
      rwm_s <= 1'b0;
      rdw_s <= '0;
      rww_s <= 1'b0;
    end else begin
      rdm_s <= RdE;
      rwm_s <= RegWriteE;
      rdw_s <= rdm_s;
      rww_s <= rwm_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallD && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (FlushD && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
